// File: rtl/memory_access_pkg.sv
// Shared types and lane helpers for the memory-access stage: size codes, FSM states,
// captured-op record and the store-lane / byte-enable rules.
package memory_access_pkg;

  localparam int ACK_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [1:0]  off;
    mem_size_e   size;
    logic        uns;
    logic        m2r;
    logic [4:0]  rd;
    logic        rwe;
    logic        st;
  } op_t;

  // Size code 3 behaves exactly like a word access.
  function automatic mem_size_e norm_size(input logic [1:0] b);
    case (b)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input mem_size_e s, input logic [1:0] off);
    case (s)
      SZ_HALF: return ~off[0];
      SZ_WORD: return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input mem_size_e s, input logic [1:0] off);
    case (s)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input mem_size_e s, input logic [31:0] wd);
    case (s)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_access_load_align.sv
// Selects the addressed lane of a load word and sign- or zero-extends it to 32 bits.
module load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0]        shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  assign shifted = rdata >> {off, 3'b000};
  assign lane_b  = signed'(shifted[7:0]);
  assign lane_h  = signed'(shifted[15:0]);

  always_comb begin
    data = shifted;
    case (size)
      SZ_BYTE: data = uns ? {24'd0, shifted[7:0]}  : 32'(lane_b);
      SZ_HALF: data = uns ? {16'd0, shifted[15:0]} : 32'(lane_h);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one data-memory transaction per captured op,
// stalls execute while waiting for ack, and retires results with error flags.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   stall_out,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            wdata_in,
  input  logic [1:0]             bytes_in,
  input  logic                   load_unsigned,
  input  logic                   we_in,
  input  logic                   re_in,
  input  logic                   mem_to_reg_in,
  input  logic [4:0]             rd_in,
  input  logic                   reg_we_in,
  memory_access_if.master        dmem,
  output logic                   run_out,
  output logic [4:0]             rd_out,
  output logic                   reg_we_out,
  output logic [31:0]            wb_data,
  output logic                   misalign_err,
  output logic                   bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic        req_q, req_d, dwe_q, dwe_d;
  logic [31:0] addr_q, addr_d, dwd_q, dwd_d;
  logic [3:0]  be_q, be_d;
  logic        run_out_q, run_out_d, reg_we_out_q, reg_we_out_d;
  logic        mis_q, mis_d, berr_q, berr_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] wb_q, wb_d;
  mem_size_e   size_in;
  logic        mem_op;
  logic [31:0] ld_data;

  assign size_in = norm_size(bytes_in);
  assign mem_op  = we_in | re_in;

  load_align u_load_align (
    .rdata (dmem.rdata),
    .off   (op_q.off),
    .size  (op_q.size),
    .uns   (op_q.uns),
    .data  (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    req_d        = req_q;
    dwe_d        = dwe_q;
    addr_d       = addr_q;
    dwd_d        = dwd_q;
    be_d         = be_q;
    rd_out_d     = rd_out_q;
    reg_we_out_d = reg_we_out_q;
    wb_d         = wb_q;
    run_out_d    = 1'b0;
    mis_d        = 1'b0;
    berr_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          rd_out_d = rd_in;
          if (!mem_op) begin
            run_out_d    = 1'b1;
            wb_d         = alu_result;
            reg_we_out_d = reg_we_in;
          end else if (!is_aligned(size_in, alu_result[1:0])) begin
            run_out_d    = 1'b1;
            reg_we_out_d = 1'b0;
            mis_d        = 1'b1;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            dwe_d   = we_in;
            addr_d  = {alu_result[31:2], 2'b00};
            dwd_d   = lane_wdata(size_in, wdata_in);
            be_d    = lane_be(size_in, alu_result[1:0]);
            op_d    = '{alu: alu_result, off: alu_result[1:0], size: size_in,
                        uns: load_unsigned, m2r: mem_to_reg_in, rd: rd_in,
                        rwe: reg_we_in, st: we_in};
          end
        end
      end
      S_ACCESS: begin
        // Ack in the final counted cycle wins over the timeout abort.
        if (dmem.ack) begin
          state_d      = S_IDLE;
          req_d        = 1'b0;
          run_out_d    = 1'b1;
          rd_out_d     = op_q.rd;
          reg_we_out_d = op_q.rwe;
          wb_d         = (op_q.st || !op_q.m2r) ? op_q.alu : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          req_d        = 1'b0;
          run_out_d    = 1'b1;
          rd_out_d     = op_q.rd;
          reg_we_out_d = 1'b0;
          berr_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      req_q        <= 1'b0;
      dwe_q        <= 1'b0;
      addr_q       <= 32'd0;
      dwd_q        <= 32'd0;
      be_q         <= 4'd0;
      run_out_q    <= 1'b0;
      rd_out_q     <= 5'd0;
      reg_we_out_q <= 1'b0;
      wb_q         <= 32'd0;
      mis_q        <= 1'b0;
      berr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      dwe_q        <= dwe_d;
      addr_q       <= addr_d;
      dwd_q        <= dwd_d;
      be_q         <= be_d;
      run_out_q    <= run_out_d;
      rd_out_q     <= rd_out_d;
      reg_we_out_q <= reg_we_out_d;
      wb_q         <= wb_d;
      mis_q        <= mis_d;
      berr_q       <= berr_d;
    end
  end

  // Captured op fields are only meaningful while in ACCESS, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  assign stall_out    = (state_q == S_ACCESS);
  assign dmem.req     = req_q;
  assign dmem.we      = dwe_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = dwd_q;
  assign dmem.be      = be_q;
  assign run_out      = run_out_q;
  assign rd_out       = rd_out_q;
  assign reg_we_out   = reg_we_out_q;
  assign wb_data      = wb_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_memory_access.sv
// Randomized and directed bench for memory_access against a behavioural reference model.
module tb_memory_access;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        stall_out;
  logic [31:0] alu_result;
  logic [31:0] wdata_in;
  logic [1:0]  bytes_in;
  logic        load_unsigned;
  logic        we_in;
  logic        re_in;
  logic        mem_to_reg_in;
  logic [4:0]  rd_in;
  logic        reg_we_in;
  logic        run_out;
  logic [4:0]  rd_out;
  logic        reg_we_out;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_err;

  memory_access_if dmem ();

  memory_access #(.ACK_TIMEOUT(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .stall_out     (stall_out),
    .alu_result    (alu_result),
    .wdata_in      (wdata_in),
    .bytes_in      (bytes_in),
    .load_unsigned (load_unsigned),
    .we_in         (we_in),
    .re_in         (re_in),
    .mem_to_reg_in (mem_to_reg_in),
    .rd_in         (rd_in),
    .reg_we_in     (reg_we_in),
    .dmem          (dmem),
    .run_out       (run_out),
    .rd_out        (rd_out),
    .reg_we_out    (reg_we_out),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_wb = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return off[0];
    return off != 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] b;
    if (sz == 2'd0)      b = 4'b0001 << off;
    else if (sz == 2'd1) b = 4'b0011 << off;
    else                 b = 4'b1111;
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (sz == 2'd1) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                         input logic uns, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * int'(off));
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Presents one op now (just after an edge) and follows it to retirement; the
  // caller is left in the retire cycle so the next op goes in back-to-back.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [1:0] sz,
                        input logic uns, input logic we, input logic re, input logic m2r,
                        input logic [4:0] rd, input logic rwe, input int ack_dly,
                        input logic [31:0] rdata);
    logic mem, mis, acked;
    mem = we | re;
    mis = mem && m_misaligned(sz, alu[1:0]);
    run = 1'b1; alu_result = alu; wdata_in = wd; bytes_in = sz; load_unsigned = uns;
    we_in = we; re_in = re; mem_to_reg_in = m2r; rd_in = rd; reg_we_in = rwe;
    @(posedge clk); #1;
    if (!mem || mis) begin
      check_eq("imm_run_out", 32'(run_out), 32'd1);
      check_eq("imm_stall", 32'(stall_out), 32'd0);
      check_eq("imm_req", 32'(dmem.req), 32'd0);
      check_eq("imm_misalign", 32'(misalign_err), 32'(mis));
      check_eq("imm_bus_err", 32'(bus_err), 32'd0);
      check_eq("imm_reg_we", 32'(reg_we_out), mis ? 32'd0 : 32'(rwe));
      if (!mis) begin
        check_eq("alu_wb", wb_data, alu);
        check_eq("alu_rd", 32'(rd_out), 32'(rd));
        last_wb = alu;
      end
      return;
    end
    acked = (ack_dly >= 0) && (ack_dly < T);
    for (int k = 0; k < T; k++) begin
      check_eq("acc_req", 32'(dmem.req), 32'd1);
      check_eq("acc_stall", 32'(stall_out), 32'd1);
      check_eq("acc_addr", dmem.addr, {alu[31:2], 2'b00});
      check_eq("acc_be", 32'(dmem.be), 32'(m_be(sz, alu[1:0])));
      check_eq("acc_we", 32'(dmem.we), 32'(we));
      if (we) check_eq("acc_wdata", dmem.wdata, m_wdata(sz, wd));
      check_eq("acc_no_retire", 32'(run_out), 32'd0);
      run = 1'($urandom_range(0, 1)); alu_result = $urandom; rd_in = 5'($urandom);
      we_in = 1'($urandom); re_in = 1'($urandom); reg_we_in = 1'($urandom);
      dmem.ack = (k == ack_dly);
      dmem.rdata = rdata;
      @(posedge clk); #1;
      dmem.ack = 1'b0;
      if (k == ack_dly) break;
    end
    check_eq("ret_run_out", 32'(run_out), 32'd1);
    check_eq("ret_req", 32'(dmem.req), 32'd0);
    check_eq("ret_stall", 32'(stall_out), 32'd0);
    check_eq("ret_misalign", 32'(misalign_err), 32'd0);
    check_eq("ret_bus_err", 32'(bus_err), acked ? 32'd0 : 32'd1);
    check_eq("ret_reg_we", 32'(reg_we_out), acked ? 32'(rwe) : 32'd0);
    if (acked) begin
      logic [31:0] exp_wb;
      exp_wb = (we || !m2r) ? alu : m_load(sz, alu[1:0], uns, rdata);
      check_eq("ret_wb", wb_data, exp_wb);
      check_eq("ret_rd", 32'(rd_out), 32'(rd));
      last_wb = exp_wb;
    end
  endtask

  task automatic go_idle();
    run = 1'b0; we_in = 1'b0; re_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; alu_result = '0; wdata_in = '0; bytes_in = '0;
    load_unsigned = 1'b0; we_in = 1'b0; re_in = 1'b0; mem_to_reg_in = 1'b0;
    rd_in = '0; reg_we_in = 1'b0; dmem.ack = 1'b0; dmem.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_run_out", 32'(run_out), 32'd0);
    check_eq("rst_stall", 32'(stall_out), 32'd0);
    check_eq("rst_req", 32'(dmem.req), 32'd0);
    check_eq("rst_wb", wb_data, 32'd0);
    check_eq("rst_be", 32'(dmem.be), 32'd0);
    reset = 1'b0;

    // Directed scenarios, issued back-to-back.
    run_op(32'h1234, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, -1, 32'h0);
    run_op(32'h1003, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 2, 32'h80FF_FFFF);
    run_op(32'h1003, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 2, 32'h80FF_FFFF);
    run_op(32'h2002, 32'hABCD, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 0, 32'h0);
    run_op(32'h3001, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b1, -1, 32'h0);
    run_op(32'h4000, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 1'b1, -1, 32'h0);
    go_idle();
    dmem.ack = 1'b1;
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    check_eq("stray_ack_run_out", 32'(run_out), 32'd0);
    check_eq("stray_ack_stall", 32'(stall_out), 32'd0);
    check_eq("stray_ack_req", 32'(dmem.req), 32'd0);
    check_eq("wb_hold", wb_data, last_wb);
    // Ack in the last counted cycle beats the timeout.
    run_op(32'h5006, 32'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b1, T - 1, 32'h8001_7FFF);

    // Reset while a load is outstanding.
    run = 1'b1; alu_result = 32'h6000; bytes_in = 2'd2; we_in = 1'b0; re_in = 1'b1;
    mem_to_reg_in = 1'b1; rd_in = 5'd3; reg_we_in = 1'b1;
    @(posedge clk); #1;
    go_idle();
    check_eq("pre_rst_req", 32'(dmem.req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("mid_rst_req", 32'(dmem.req), 32'd0);
    check_eq("mid_rst_stall", 32'(stall_out), 32'd0);
    check_eq("mid_rst_run_out", 32'(run_out), 32'd0);
    check_eq("mid_rst_wb", wb_data, 32'd0);
    @(posedge clk); #1;
    check_eq("post_rst_run_out", 32'(run_out), 32'd0);
    last_wb = 32'd0;

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          kind;
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz != 2'd0) a[1:0] = 2'b00;
      end
      run_op(a, $urandom, sz, 1'($urandom), kind == 2, kind == 1, 1'($urandom),
             5'($urandom), 1'($urandom), $urandom_range(0, 5) - 0, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        @(posedge clk); #1;
        check_eq("gap_run_out", 32'(run_out), 32'd0);
        check_eq("gap_wb_hold", wb_data, last_wb);
      end
    end
    go_idle();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
